// File: rtl/top_pkg.sv
// top_pkg: shared constants and helpers for the Pan-Tompkins front end.
// Tap offsets, shift amounts, accumulator widths and saturation.
package top_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  localparam int LPF_TAP_A = 6;
  localparam int LPF_TAP_B = 12;
  localparam int HPF_TAP_MID = 16;
  localparam int HPF_TAP_LEN = 32;

  localparam int LPF_SHIFT = 5;
  localparam int HPF_SHIFT = 5;
  localparam int DER_SHIFT = 3;

  localparam int LPF_ACC_W = 24;
  localparam int HPF_ACC_W = 24;
  localparam int SAT_W = 48;

  // Clamp a wide signed value into a w-bit two's complement range.
  function automatic logic signed [SAT_W-1:0] sat(
    input logic signed [SAT_W-1:0] v,
    input int w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_W'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/moving_window_integrator.sv
// moving_window_integrator: mean of the last MWI_LEN samples.
// Ports: clk, rstn (sync, active-high), en, din (>=0), dout (registered).
module moving_window_integrator
  import top_pkg::*;
#(
  parameter int MWI_LEN = 32,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] din,
  output logic signed [DATA_WIDTH-1:0] dout
);

  localparam int LOG = $clog2(MWI_LEN);
  localparam int SUM_W = DATA_WIDTH + LOG;

  logic [DATA_WIDTH-1:0] mem [MWI_LEN];
  logic [LOG-1:0]        ptr;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      sum_n;

  // mem[ptr] holds the sample leaving the window this step.
  always_comb begin
    sum_n = sum
          + SUM_W'($unsigned(din))
          - SUM_W'(mem[ptr]);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < MWI_LEN; i++) begin
        mem[i] <= '0;
      end
      ptr  <= '0;
      sum  <= '0;
      dout <= '0;
    end else if (en) begin
      mem[ptr] <= din;
      ptr      <= ptr + 1'b1;
      sum      <= sum_n;
      dout     <= DATA_WIDTH'(sum_n >> LOG);
    end
  end

endmodule

// File: rtl/top.sv
// top: Pan-Tompkins LPF -> HPF -> derivative -> square -> MWI chain.
// Ports: clk, rstn (sync, active-high), en, xin, y. Macro: TOP_MWI_EN.
module top
  import top_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SQ_SHIFT = 8,
  parameter int MWI_LEN = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] xin,
  output logic signed [DATA_WIDTH-1:0] y
);

  localparam int W = DATA_WIDTH;
  localparam int DW = W + 3;
  localparam int HW = HPF_ACC_W + 2;

  if ((MWI_LEN < 2) || ((MWI_LEN & (MWI_LEN - 1)) != 0)) begin : g_chk
    $error("MWI_LEN must be a power of two >= 2");
  end

  logic signed [W-1:0]         xh [1:LPF_TAP_B];
  logic signed [LPF_ACC_W-1:0] l1;
  logic signed [LPF_ACC_W-1:0] l2;
  logic signed [W-1:0]         u;
  logic signed [W-1:0]         uh [1:HPF_TAP_LEN];
  logic signed [HPF_ACC_W-1:0] p;
  logic signed [W-1:0]         v;
  logic signed [W-1:0]         vh [1:4];
  logic signed [W-1:0]         d;
  logic signed [W-1:0]         s;

  logic signed [LPF_ACC_W-1:0] l_n;
  logic signed [HPF_ACC_W-1:0] p_n;
  logic signed [HW-1:0]        hx;
  logic signed [DW-1:0]        dx;
  logic signed [2*W-1:0]       dd;
  logic signed [2*W-1:0]       sq;
  logic signed [W-1:0]         u_n;
  logic signed [W-1:0]         h_n;
  logic signed [W-1:0]         d_n;
  logic signed [W-1:0]         s_n;

  always_comb begin
    l_n = (l1 <<< 1) - l2
        + LPF_ACC_W'(xin)
        - (LPF_ACC_W'(xh[LPF_TAP_A]) <<< 1)
        + LPF_ACC_W'(xh[LPF_TAP_B]);
    u_n = W'(sat(SAT_W'(l_n >>> LPF_SHIFT), W));

    p_n = p + HPF_ACC_W'(u)
        - HPF_ACC_W'(uh[HPF_TAP_LEN]);
    // 32*u[n-16] realised as a shift by the same 5
    hx  = (HW'(uh[HPF_TAP_MID]) <<< HPF_SHIFT)
        - HW'(p_n);
    h_n = W'(sat(SAT_W'(hx >>> HPF_SHIFT), W));

    dx  = (DW'(v) <<< 1) + DW'(vh[1])
        - DW'(vh[3]) - (DW'(vh[4]) <<< 1);
    d_n = W'(sat(SAT_W'(dx >>> DER_SHIFT), W));

    // square is never negative, so only the top clamp can fire
    dd  = (2*W)'(d);
    sq  = (dd * dd) >>> SQ_SHIFT;
    s_n = W'(sat(SAT_W'(sq), W));
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 1; i <= LPF_TAP_B; i++) begin
        xh[i] <= '0;
      end
      for (int i = 1; i <= HPF_TAP_LEN; i++) begin
        uh[i] <= '0;
      end
      for (int i = 1; i <= 4; i++) begin
        vh[i] <= '0;
      end
      l1 <= '0;
      l2 <= '0;
      u  <= '0;
      p  <= '0;
      v  <= '0;
      d  <= '0;
      s  <= '0;
    end else if (en) begin
      xh[1] <= xin;
      for (int i = 2; i <= LPF_TAP_B; i++) begin
        xh[i] <= xh[i-1];
      end
      l2 <= l1;
      l1 <= l_n;
      u  <= u_n;

      uh[1] <= u;
      for (int i = 2; i <= HPF_TAP_LEN; i++) begin
        uh[i] <= uh[i-1];
      end
      p <= p_n;
      v <= h_n;

      vh[1] <= v;
      for (int i = 2; i <= 4; i++) begin
        vh[i] <= vh[i-1];
      end
      d <= d_n;
      s <= s_n;
    end
  end

`ifdef TOP_MWI_EN
  moving_window_integrator #(
    .MWI_LEN   (MWI_LEN),
    .DATA_WIDTH(W)
  ) u_mwi (
    .clk (clk),
    .rstn(rstn),
    .en  (en),
    .din (s),
    .dout(y)
  );
`else
  assign y = s;
`endif

endmodule

// File: tb/tb_top.sv
// tb_top: directed vectors plus sample-indexed reference for top.
// Drives clk/rstn/en/xin, checks y one time unit after each edge.
module tb_top;

  localparam int NM = 512;
  localparam int AX = 0;
  localparam int AL = 1;
  localparam int AU = 2;
  localparam int AP = 3;
  localparam int AH = 4;
  localparam int AS = 5;

  logic               clk = 1'b0;
  logic               rstn = 1'b1;
  logic               en = 1'b0;
  logic signed [15:0] xin = '0;
  logic signed [15:0] y;

  int checks = 0;
  int errors = 0;
  int n = 0;
  longint mdat [0:5][0:NM-1];

  typedef struct {
    logic               rst;
    logic               en;
    logic signed [15:0] x;
    logic signed [15:0] y;
  } vec_t;

  vec_t tv[$];

  top dut (
    .clk (clk),
    .rstn(rstn),
    .en  (en),
    .xin (xin),
    .y   (y)
  );

  always #5 clk = ~clk;

  function automatic longint at(int a, int i);
    if (i < 0) return 0;
    return mdat[a][i];
  endfunction

  function automatic longint satm(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Direct evaluation of each stage's difference equation at sample n.
  task automatic push(longint x);
    longint l;
    longint p;
    longint h;
    longint dv;
    longint sv;
    mdat[AX][n] = x;
    l = 2 * at(AL, n-1) - at(AL, n-2)
      + x - 2 * at(AX, n-6) + at(AX, n-12);
    mdat[AL][n] = l;
    mdat[AU][n] = satm(l >>> 5);
    p = at(AP, n-1) + at(AU, n) - at(AU, n-32);
    mdat[AP][n] = p;
    h = satm((32 * at(AU, n-16) - p) >>> 5);
    mdat[AH][n] = h;
    dv = satm((2 * h + at(AH, n-1) - at(AH, n-3)
              - 2 * at(AH, n-4)) >>> 3);
    sv = (dv * dv) >>> 8;
    if (sv > 32767) sv = 32767;
    mdat[AS][n] = sv;
    n++;
  endtask

  // y after the edge that consumed sample n-1
  function automatic longint yexp();
`ifdef TOP_MWI_EN
    longint sum;
    int m;
    sum = 0;
    m = n - 5;
    if (m < 0) return 0;
    for (int i = 0; i < 32; i++) begin
      sum += at(AS, m - i);
    end
    return sum >>> 5;
`else
    return at(AS, n - 4);
`endif
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: y=%0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(logic r, logic e, logic signed [15:0] x);
    rstn = r;
    en = e;
    xin = x;
    @(posedge clk);
    #1;
    if (r) n = 0;
    else if (e) push(longint'(x));
  endtask

  task automatic run_step(int cnt, string nm, bit dc);
    for (int i = 0; i < cnt; i++) begin
      tick(1'b0, 1'b1, 16'sd1000);
      chk(nm, y, yexp());
      if (dc && i >= 100) chk("dc_zero", y, 0);
    end
  endtask

  initial begin
    bit pos;
    logic signed [15:0] xv;

    for (int i = 0; i < 3; i++)
      tv.push_back('{1'b1, 1'b1, 16'sd1000, 16'sd0});
    tv.push_back('{1'b0, 1'b1, 16'sd0, 16'sd0});
    for (int i = 0; i < 2; i++)
      tv.push_back('{1'b0, 1'b0, 16'sd1000, 16'sd0});
    for (int i = 0; i < 200; i++)
      tv.push_back('{1'b0, 1'b1, 16'sd0, 16'sd0});

    foreach (tv[i]) begin
      tick(tv[i].rst, tv[i].en, tv[i].x);
      chk($sformatf("vec%0d", i), y, tv[i].y);
    end

    // step, DC rejection
    tick(1'b1, 1'b1, 16'sd0);
    chk("rst", y, 0);
    pos = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick(1'b0, 1'b1, 16'sd1000);
      chk("step", y, yexp());
      if (y > 0) pos = 1'b1;
      if (i >= 100) chk("dc_zero", y, 0);
    end
    chk("step_rise", longint'(pos), 1);

    // freeze mid-response
    tick(1'b1, 1'b1, 16'sd0);
    run_step(30, "pre_freeze", 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b0, -16'sd5000);
      chk("freeze", y, yexp());
    end
    run_step(120, "resume", 1'b0);

    // full-scale alternating and square wave
    tick(1'b1, 1'b1, 16'sd0);
    for (int i = 0; i < 100; i++) begin
      xv = (i % 2 == 1) ? -16'sd32768 : 16'sd32767;
      tick(1'b0, 1'b1, xv);
      chk("alt", y, yexp());
      chk("alt_nonneg", longint'(y >= 0), 1);
    end
    tick(1'b1, 1'b1, 16'sd0);
    for (int i = 0; i < 128; i++) begin
      xv = ((i / 16) % 2 == 1) ? -16'sd32768 : 16'sd32767;
      tick(1'b0, 1'b1, xv);
      chk("sq", y, yexp());
      chk("sq_nonneg", longint'(y >= 0), 1);
    end

    // reset mid-response, en low, then fresh replay
    tick(1'b1, 1'b1, 16'sd0);
    run_step(40, "pre_rst", 1'b0);
    tick(1'b1, 1'b0, 16'sd1000);
    chk("rst_prio", y, 0);
    run_step(150, "replay", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
